// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
// Holds the stage FSM state encoding and the width of the occupancy count.
// Imported by the top-level stage; the data slot itself needs nothing from here.
package pipe_pkg;

  // Occupancy-coded stage state: EMPTY = 0 entries, BUSY = main slot only,
  // FULL = main + skid. The 2'b11 encoding is illegal and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  localparam int PIPE_CNT_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// Purpose: one WIDTH-bit data slot of the pipeline stage (main or skid entry).
// Latency: a load or clear takes effect on the next rising clk edge.
// Backpressure: none of its own; the owning stage decides when to load.
// Ports: clk/rst (async, active-high, loads RESET_VAL), load (capture d),
//        clear (load RESET_VAL, wins over load), d (next payload), q (stored payload).
module pipe_slot #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = RESET_VAL;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Purpose: valid/ready pipeline stage register with a 2-entry skid buffer and flush.
// Latency: 1 cycle from in_fire to out_valid when empty; 1 beat/cycle sustained.
// Backpressure: in_ready comes from the state register only (low when both slots are
//   full), so there is no combinational path from out_ready to in_ready.
// Ports: clk, rst (async, active-high), flush (sync kill of stored entries),
//   in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream),
//   count (occupancy 0..2).
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [PIPE_CNT_W-1:0] count
);

  pipe_state_t state_d;
  pipe_state_t state_q;

  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic             slot_clear;
  logic [WIDTH-1:0] main_in;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs decode the registered state only.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    count = '0;
    case (state_q)
      EMPTY:   count = 2'd0;
      BUSY:    count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // Next-state and slot-load decode. Flush overrides every transfer: the stage
  // empties and a same-cycle input beat is dropped, not captured.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            // Old head leaves as the new beat replaces it: occupancy unchanged.
            main_load = 1'b1;
          end else if (in_fire) begin
            // Downstream stalled: park the new (younger) beat in the skid slot.
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d        = BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  assign main_in    = main_from_skid ? skid_q : in_data;
  assign slot_clear = flush & CLEAR_ON_FLUSH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (slot_clear),
    .d     (main_in),
    .q     (main_q)
  );

  pipe_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (slot_clear),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Purpose: directed and randomised self-checking bench for pipe_reg_skid.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: out_ready driven by directed vectors and by random stimulus.
module tb_pipe_reg_skid;

  localparam logic [31:0] RV_C = 32'hCAFE_F00D;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Directed stimulus, shared by the plain and the clear-on-flush instances.
  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_count;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [1:0]  c_count;

  // Random stimulus, shared by the 8-bit and 64-bit instances.
  logic        r_flush, r_in_valid, r_out_ready;
  logic [63:0] r_in_data;

  logic        w8_in_ready, w8_out_valid;
  logic [7:0]  w8_out_data;
  logic [1:0]  w8_count;
  logic        w64_in_ready, w64_out_valid;
  logic [63:0] w64_out_data;
  logic [1:0]  w64_count;

  pipe_reg_skid #(.WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  pipe_reg_skid #(.WIDTH(32), .RESET_VAL(RV_C), .CLEAR_ON_FLUSH(1'b1)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .count(c_count)
  );

  pipe_reg_skid #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst(rst), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(w8_in_ready), .in_data(r_in_data[7:0]),
    .out_valid(w8_out_valid), .out_ready(r_out_ready), .out_data(w8_out_data),
    .count(w8_count)
  );

  pipe_reg_skid #(.WIDTH(64)) dut_w64 (
    .clk(clk), .rst(rst), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(w64_in_ready), .in_data(r_in_data),
    .out_valid(w64_out_valid), .out_ready(r_out_ready), .out_data(w64_out_data),
    .count(w64_count)
  );

  task automatic test_reset();
    // Load a beat so there is something to discard.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", a_out_data); end
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", a_count); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (c_out_data !== RV_C) begin errors++; $display("FAIL reset_val_c: got %h expected %h", c_out_data, RV_C); end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_release_count: got %0d expected 0", a_count); end
  endtask

  task automatic test_streaming();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'd1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (a_out_data !== 32'(i - 1)) begin errors++; $display("FAIL stream_data_%0d: got %h expected %h", i - 1, a_out_data, 32'(i - 1)); end
      checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL stream_count_%0d: got %0d expected 1", i - 1, a_count); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready_%0d: got %b expected 1", i - 1, a_in_ready); end
      in_data = 32'(i);
    end
    @(negedge clk);
    checks++; if (a_out_data !== 32'd4) begin errors++; $display("FAIL stream_data_4: got %h expected 4", a_out_data); end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid_4: got %b expected 1", a_out_valid); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL stream_drain_count: got %0d expected 0", a_count); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    @(negedge clk);
    checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL bp_count_1: got %0d expected 1", a_count); end
    in_data = 32'hB;
    @(negedge clk);
    checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL bp_count_2: got %0d expected 2", a_count); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", a_in_ready); end
    checks++; if (a_out_data !== 32'hA) begin errors++; $display("FAIL bp_head: got %h expected 0000000a", a_out_data); end
    // Offered beat while full must be ignored.
    in_data = 32'hE;
    @(negedge clk);
    checks++; if (a_out_data !== 32'hA || a_count !== 2'd2) begin errors++; $display("FAIL bp_hold: got %h/%0d expected 0000000a/2", a_out_data, a_count); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_data !== 32'hB || a_count !== 2'd1) begin errors++; $display("FAIL bp_second: got %h/%0d expected 0000000b/1", a_out_data, a_count); end
    @(negedge clk);
    checks++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0d/%b expected 0/0", a_count, a_out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    @(negedge clk);
    in_data = 32'hB;
    @(negedge clk);
    checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL flush_fill: got %0d expected 2", a_count); end
    flush = 1'b1; in_data = 32'hC;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_full: got %b expected 0", a_in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_empty: got %0d/%b expected 0/0", a_count, a_out_valid); end
    checks++; if (a_out_data !== 32'hA) begin errors++; $display("FAIL flush_keep_data: got %h expected 0000000a", a_out_data); end
    checks++; if (c_out_data !== RV_C || c_count !== 2'd0) begin errors++; $display("FAIL flush_clear_data: got %h/%0d expected %h/0", c_out_data, c_count, RV_C); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost_%0d: got %b expected 0", i, a_out_valid); end
    end
    // Flush from BUSY while a beat is accepted: the beat is dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD;
    @(negedge clk);
    checks++; if (a_out_data !== 32'hD || a_count !== 2'd1) begin errors++; $display("FAIL flush_busy_load: got %h/%0d expected 0000000d/1", a_out_data, a_count); end
    flush = 1'b1; in_data = 32'hE;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_busy: got %b expected 1", a_in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy_empty: got %0d/%b expected 0/0", a_count, a_out_valid); end
    checks++; if (c_out_data !== RV_C) begin errors++; $display("FAIL flush_busy_clear: got %h expected %h", c_out_data, RV_C); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy_no_ghost: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
    @(negedge clk);
    checks++; if (a_out_data !== 32'h5 || a_count !== 2'd1) begin errors++; $display("FAIL sim_load: got %h/%0d expected 00000005/1", a_out_data, a_count); end
    out_ready = 1'b1; in_data = 32'h6;
    @(negedge clk);
    checks++; if (a_out_data !== 32'h6 || a_count !== 2'd1) begin errors++; $display("FAIL sim_replace: got %h/%0d expected 00000006/1", a_out_data, a_count); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL sim_drain: got %0d expected 0", a_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] sb[$];
    logic        stall_prev = 1'b0;
    logic [63:0] prev64 = '0;
    logic [7:0]  prev8 = '0;
    int          err_start = errors;
    bit          in_fire, out_fire;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      checks++; if (w64_count !== 2'(sb.size())) begin errors++; $display("FAIL rnd64_count cyc %0d: got %0d expected %0d", cyc, w64_count, sb.size()); end
      checks++; if (w8_count !== 2'(sb.size())) begin errors++; $display("FAIL rnd8_count cyc %0d: got %0d expected %0d", cyc, w8_count, sb.size()); end
      checks++; if (w64_in_ready !== (sb.size() < 2)) begin errors++; $display("FAIL rnd64_in_ready cyc %0d: got %b expected %b", cyc, w64_in_ready, sb.size() < 2); end
      checks++; if (w64_out_valid !== (sb.size() != 0) || w8_out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL rnd_out_valid cyc %0d: got %b/%b expected %b", cyc, w64_out_valid, w8_out_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        checks++; if (w64_out_data !== sb[0]) begin errors++; $display("FAIL rnd64_data cyc %0d: got %h expected %h", cyc, w64_out_data, sb[0]); end
        checks++; if (w8_out_data !== sb[0][7:0]) begin errors++; $display("FAIL rnd8_data cyc %0d: got %h expected %h", cyc, w8_out_data, sb[0][7:0]); end
      end
      if (stall_prev) begin
        checks++; if (w64_out_data !== prev64 || w8_out_data !== prev8) begin errors++; $display("FAIL rnd_stable cyc %0d: got %h/%h expected %h/%h", cyc, w64_out_data, w8_out_data, prev64, prev8); end
      end
      if (errors - err_start > 20) break;
      r_in_valid  = 1'($urandom_range(0, 1));
      r_out_ready = 1'($urandom_range(0, 1));
      r_in_data   = {$urandom(), $urandom()};
      in_fire  = r_in_valid && (sb.size() < 2);
      out_fire = r_out_ready && (sb.size() != 0);
      stall_prev = (sb.size() != 0) && !r_out_ready;
      prev64 = w64_out_data;
      prev8  = w8_out_data;
      if (out_fire) void'(sb.pop_front());
      if (in_fire) sb.push_back(r_in_data);
    end
    @(negedge clk);
    r_in_valid = 1'b0; r_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    r_flush = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0; r_in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
